dmem_responder: RTL

- Multi-cycle data-memory responder: the slave end of the CPU's MEM-stage load/store interface.
- Accepts one word request at a time, holds the pipeline with a stall while the access is in flight, then completes it with a one-cycle acknowledge.
- Replaces the single-cycle data memory so the pipeline can be exercised against realistic memory latency.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_array.sv | 30 +++
 rtl/dmem_responder.sv | 97 +++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int unsigned idx_width(input int unsigned depth_words);
    return $clog2(depth_words);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned latency);
    return $clog2(latency) + 1;
  endfunction

  // Misaligned word access or byte address beyond the last stored word.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth_words);
    logic [33:0] limit;
    limit = {2'b00, depth_words} << 2;
    return (addr[1:0] != 2'b00) || ({2'b00, addr} >= limit);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with synchronous write, registered read port and async clear.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 32,
  parameter int unsigned IDX_W       = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             rd_zero,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (wr_en) mem[idx] <= wdata;
      if (rd_en) rdata <= rd_zero ? '0 : mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage slave: accepts one word request, stalls for LATENCY cycles,
// then completes with a single-cycle acknowledge.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 32,
  parameter int unsigned LATENCY     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned IDX_W = idx_width(DEPTH_WORDS);
  localparam int unsigned CNT_W = cnt_width(LATENCY);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             lat_we;
  logic [31:0]      lat_addr;
  logic [31:0]      lat_wdata;
  logic             resp_err;

  logic             enter_resp;
  logic             acc_we;
  logic [31:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic             acc_err;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_i) state_nx = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt == CNT_W'(1)) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // With LATENCY==1 the access happens on the accepting edge, before the
  // latch is loaded, so the live request must feed the array directly.
  always_comb begin
    enter_resp = (state_nx == RESP) && (state != RESP);
    acc_we     = (state == IDLE) ? we_i    : lat_we;
    acc_addr   = (state == IDLE) ? addr_i  : lat_addr;
    acc_wdata  = (state == IDLE) ? wdata_i : lat_wdata;
    acc_err    = addr_err(acc_addr, DEPTH_WORDS);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      resp_err  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_i) begin
        cnt       <= CNT_W'(LATENCY - 1);
        lat_we    <= we_i;
        lat_addr  <= addr_i;
        lat_wdata <= wdata_i;
      end else if (state == WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (enter_resp) resp_err <= acc_err;
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .wr_en   (enter_resp && acc_we && !acc_err),
    .rd_en   (enter_resp && !acc_we),
    .rd_zero (acc_err),
    .idx     (acc_addr[IDX_W+1:2]),
    .wdata   (acc_wdata),
    .rdata   (rdata_o)
  );

  assign stall_o = (state == IDLE && req_i) || (state == WAIT);
  assign ack_o   = (state == RESP);
  assign err_o   = (state == RESP) && resp_err;

endmodule
